// File: rtl/wb_host_bridge.sv
// wb_host_bridge: single-outstanding host request to Wishbone classic master.
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   req_valid_i / req_ready_o     host request handshake
//   req_we_i, req_sel_i,
//   req_addr_i, req_wdata_i       request fields, latched on handshake
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_err_o        response payload
//   wbm_*                         Wishbone classic master port
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready for a host request, Wishbone bus idle
// BUS   | cyc/stb asserted, waiting for ack/err or timeout
// RESP  | response held on rsp_* until the host accepts it
module wb_host_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [DATA_W/8-1:0] req_sel_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i
);

  localparam bit TO_EN = (TIMEOUT > 0);
  // A zero-width counter is not legal, so keep one bit when timeout is disabled.
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t state_q, state_d;

  logic                we_q;
  logic [DATA_W/8-1:0] sel_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic             bus_done;
  logic             to_hit;
  logic [CNT_W-1:0] cnt_inc;

  assign bus_done = wbm_ack_i | wbm_err_i;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  // Timeout fires on the edge where the count would reach TIMEOUT, so the
  // bus is held for exactly TIMEOUT cycles.
  assign to_hit   = TO_EN && !bus_done && (cnt_inc == TO_CNT);

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = BUS;
      BUS:     if (bus_done || to_hit) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    req_ready_o = (state_q == IDLE);
    wbm_cyc_o   = (state_q == BUS);
    wbm_stb_o   = (state_q == BUS);
    rsp_valid_o = (state_q == RESP);
  end

  // request latch, response capture and timeout counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q  <= req_we_i;
            sel_q <= req_sel_i;
            adr_q <= req_addr_i;
            dat_q <= req_wdata_i;
            cnt_q <= '0;
          end
        end
        BUS: begin
          if (bus_done) begin
            // err wins over ack; only a clean read ack returns data
            err_q   <= wbm_err_i;
            rdata_q <= (wbm_ack_i && !wbm_err_i && !we_q) ? wbm_dat_i : '0;
          end else begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_inc;
            if (to_hit) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_wb_host_bridge.sv
module tb_wb_host_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [3:0]  req_sel_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wb_host_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_sel_i(req_sel_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the bridge idle; returns #1 after the handshake edge.
  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata);
    chk("req_ready_before", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_sel_i   = sel;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  // Plays the slave: answers on the (waits+1)-th BUS cycle, counts cyc cycles,
  // and checks the master fields hold the request. Returns at the negedge after cyc drops.
  task automatic bus_xfer(input int waits, input logic ack, input logic err,
                          input logic [31:0] dat, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int cycles);
    bit done = 0;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (!wbm_cyc_o) begin
        done = 1;
        break;
      end
      cycles++;
      chk("stb_eq_cyc", wbm_stb_o, wbm_cyc_o);
      chk("bus_we", wbm_we_o, we);
      chk("bus_sel", wbm_sel_o, sel);
      chk("bus_adr", wbm_adr_o, addr);
      chk("bus_dat", wbm_dat_o, wdata);
      chk("bus_no_rsp", rsp_valid_o, 1'b0);
      if (cycles == waits + 1) begin
        wbm_ack_i = ack;
        wbm_err_i = err;
        wbm_dat_i = dat;
      end
      @(posedge clk_i); #1;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = '0;
    end
    chk("bus_terminated", done, 1'b1);
  endtask

  // At a negedge in RESP: hold rsp_ready low for 'hold' cycles, then accept.
  task automatic rsp_accept(input int hold, input logic [31:0] rdata, input logic err);
    chk("rsp_valid", rsp_valid_o, 1'b1);
    chk("rsp_rdata", rsp_rdata_o, rdata);
    chk("rsp_err", rsp_err_o, err);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hDEAD_BEEF;
      end
      @(posedge clk_i); #1;
      wbm_ack_i = 1'b0;
      wbm_dat_i = '0;
      @(negedge clk_i);
      chk("hold_valid", rsp_valid_o, 1'b1);
      chk("hold_rdata", rsp_rdata_o, rdata);
      chk("hold_err", rsp_err_o, err);
      chk("hold_ready", req_ready_o, 1'b0);
      chk("hold_cyc", wbm_cyc_o, 1'b0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    chk("rsp_done_valid", rsp_valid_o, 1'b0);
    chk("rsp_done_ready", req_ready_o, 1'b1);
    chk("idle_cyc_low", wbm_cyc_o, 1'b0);
  endtask

  initial begin
    int cyc_n;

    #12;
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_we", wbm_we_o, 1'b0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_err", rsp_err_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // read, two wait states
    issue(1'b0, 4'hF, 32'h3000_0004, 32'h0);
    bus_xfer(2, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h3000_0004, 32'h0, cyc_n);
    chk("read_cyc_cycles", cyc_n, 3);
    rsp_accept(0, 32'hCAFE_F00D, 1'b0);

    // write, zero wait; response held back 5 cycles with a stray ack
    issue(1'b1, 4'hF, 32'h3000_0000, 32'h1234_5678);
    bus_xfer(0, 1'b1, 1'b0, 32'h5555_AAAA, 1'b1, 4'hF, 32'h3000_0000, 32'h1234_5678, cyc_n);
    chk("write_cyc_cycles", cyc_n, 1);
    rsp_accept(5, 32'h0, 1'b0);

    // timeout with silent slave
    issue(1'b0, 4'h3, 32'h3000_0008, 32'h0);
    bus_xfer(100, 1'b0, 1'b0, 32'h0, 1'b0, 4'h3, 32'h3000_0008, 32'h0, cyc_n);
    chk("timeout_cyc_cycles", cyc_n, 4);
    rsp_accept(0, 32'h0, 1'b1);

    // ack and err together
    issue(1'b0, 4'hF, 32'h3000_000C, 32'h0);
    bus_xfer(1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'hF, 32'h3000_000C, 32'h0, cyc_n);
    chk("ackerr_cyc_cycles", cyc_n, 2);
    rsp_accept(0, 32'h0, 1'b1);

    // err alone on a write with partial select
    issue(1'b1, 4'h5, 32'h3000_0010, 32'hA5A5_0F0F);
    bus_xfer(0, 1'b0, 1'b1, 32'h0, 1'b1, 4'h5, 32'h3000_0010, 32'hA5A5_0F0F, cyc_n);
    chk("err_cyc_cycles", cyc_n, 1);
    rsp_accept(1, 32'h0, 1'b1);

    // async reset mid-BUS
    issue(1'b0, 4'hF, 32'h3000_0020, 32'h0);
    @(negedge clk_i);
    chk("pre_rst_cyc", wbm_cyc_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_cyc", wbm_cyc_o, 1'b0);
    chk("async_rst_stb", wbm_stb_o, 1'b0);
    chk("async_rst_ready", req_ready_o, 1'b1);
    chk("async_rst_valid", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("post_rst_no_rsp", rsp_valid_o, 1'b0);
      chk("post_rst_no_cyc", wbm_cyc_o, 1'b0);
    end

    issue(1'b0, 4'hF, 32'h3000_0024, 32'h0);
    bus_xfer(0, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 4'hF, 32'h3000_0024, 32'h0, cyc_n);
    chk("post_rst_cyc_cycles", cyc_n, 1);
    rsp_accept(0, 32'h0BAD_F00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_host_bridge.md
WB_HOST_BRIDGE -- requirements
Module: wb_host_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, Wishbone address width.
REQ-002 Parameter DATA_W, default 32, Wishbone data width; sel width is DATA_W/8.
REQ-003 Parameter TIMEOUT, default 255, max BUS-state cycles awaiting ack/err; 0 disables timeout.
REQ-004 clk_i  in  1  single clock, all logic rising-edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 req_valid_i  in  1  host request valid.
REQ-007 req_ready_o  out  1  bridge accepts request.
REQ-008 req_we_i  in  1  1=write, 0=read.
REQ-009 req_sel_i  in  DATA_W/8  byte selects.
REQ-010 req_addr_i  in  ADDR_W  byte address.
REQ-011 req_wdata_i  in  DATA_W  write data.
REQ-012 rsp_valid_o  out  1  response valid.
REQ-013 rsp_ready_i  in  1  host accepts response.
REQ-014 rsp_rdata_o  out  DATA_W  read data (0 for writes and errors).
REQ-015 rsp_err_o  out  1  transfer ended by err or timeout.
REQ-016 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-017 wbm_sel_o  out  DATA_W/8; wbm_adr_o  out  ADDR_W; wbm_dat_o  out  DATA_W.
REQ-018 wbm_dat_i  in  DATA_W; wbm_ack_i  in  1; wbm_err_i  in  1  slave responses.

Function
REQ-019 FSM states IDLE, BUS, RESP; reset state IDLE.
REQ-020 req_ready_o SHALL be 1 only in IDLE; handshake = req_valid_i & req_ready_o at a rising edge.
REQ-021 On handshake: latch we/sel/addr/wdata, go BUS; wbm_cyc_o=wbm_stb_o=1 from next cycle.
REQ-022 In BUS, wbm_we_o/sel_o/adr_o/dat_o SHALL hold latched values, stable until termination.
REQ-023 Termination: edge with cyc&stb and (ack_i | err_i); cyc/stb drop after that edge; go RESP.
REQ-024 ack_i and err_i both high: treated as error; rsp_err_o=1, rsp_rdata_o=0.
REQ-025 Read with ack: rsp_rdata_o = wbm_dat_i sampled at termination edge; write: rsp_rdata_o=0.
REQ-026 Timeout counter clears on BUS entry, increments each BUS cycle without ack/err; at count==TIMEOUT (TIMEOUT>0) drop cyc/stb, go RESP with rsp_err_o=1, rdata=0.
REQ-027 Counter width clog2(TIMEOUT+1), never wraps.
REQ-028 RESP: rsp_valid_o=1, rdata/err stable until rsp_ready_i handshake; then IDLE.
REQ-029 Minimum latency: handshake edge N, cyc at N..N+1, ack at edge N+1, rsp_valid_o high after edge N+1.
REQ-030 cyc/stb SHALL be low at least one cycle between consecutive transfers (no pipelining, no burst).
REQ-031 ack_i/err_i outside BUS SHALL be ignored; no state change.
REQ-032 wbm_cyc_o and wbm_stb_o SHALL always be equal.

Reset
REQ-033 rst_ni low SHALL immediately (asynchronously) force IDLE, cyc/stb/we=0, sel/adr/dat_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, counter=0.
REQ-034 Reset mid-BUS aborts transfer with no response generated; after release req_ready_o=1.

Verification
REQ-035 Read: addr 0x3000_0004, slave acks after 2 wait cycles with 0xCAFE_F00D -> cyc high 3 cycles, rsp_rdata_o=0xCAFE_F00D, rsp_err_o=0.
REQ-036 Write: addr 0x3000_0000, wdata 0x1234_5678, sel 0xF, zero-wait ack -> wbm_we_o=1, dat_o stable while cyc, rsp_rdata_o=0, rsp_err_o=0.
REQ-037 Timeout: TIMEOUT=4, slave never responds -> cyc drops after 4 BUS cycles, rsp_err_o=1, rsp_rdata_o=0.
REQ-038 Simultaneous ack_i and err_i on a read returning 0xFFFF_FFFF -> rsp_err_o=1, rsp_rdata_o=0.
REQ-039 Response backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o/rdata stable, req_ready_o=0, no new cyc; stray ack_i ignored.
REQ-040 rst_ni pulsed low mid-BUS -> cyc/stb low without clock edge, no rsp_valid_o, next request completes normally.
